add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter WIDTH, default 15, operand/sum width in bits.
REQ-002 Parameter LATENCY, default 2, cycles from operand issue to valid add_sum on the shared pipelined adder; legal range 1..8.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 en  input  1  high = new grants allowed; low = no new grants, in-flight ops drain.
REQ-006 req_valid0 / req_valid1  input  1 each  requester 0/1 has an operand pair.
REQ-007 req_ready0 / req_ready1  output  1 each  requester 0/1 granted this cycle.
REQ-008 req_x0, req_y0, req_x1, req_y1  input  WIDTH each  requester operands.
REQ-009 add_x, add_y  output  WIDTH each  operands to the shared adder.
REQ-010 add_sum  input  WIDTH  shared adder result, LATENCY cycles after issue.
REQ-011 resp_valid0 / resp_valid1  output  1 each  registered one-cycle response strobe per requester; no backpressure.
REQ-012 resp_sum  output  WIDTH  registered result, meaningful only while a resp_valid is high.
REQ-013 cnt0, cnt1  output  16 each  per-requester issue counters (see Configuration).

Function
REQ-014 Handshake: a transfer on requester k occurs in a cycle with req_validk and req_readyk both high.
REQ-015 req_readyk is combinational from en, both req_valid inputs and the priority pointer; at most one ready is high per cycle.
REQ-016 en low -> both req_ready low.
REQ-017 en high, only one requester valid -> that requester ready, regardless of pointer.
REQ-018 en high, both valid -> requester selected by the 1-bit priority pointer ready; the other waits.
REQ-019 The pointer updates only on a transfer, to the non-granted requester; otherwise it holds.
REQ-020 add_x/add_y equal the operands of the granted requester in a transfer cycle; otherwise they are 0.
REQ-021 A tag shift register of depth LATENCY carries {valid, requester id}; stage 0 loads on every clock edge, valid = transfer that cycle.
REQ-022 When the tag at stage LATENCY-1 is valid, on the next edge resp_sum <= add_sum and resp_valid of the tagged requester <= 1; otherwise both resp_valid <= 0 and resp_sum holds.
REQ-023 Total latency: transfer at edge t -> response visible after edge t+LATENCY; one result per cycle sustained, back-to-back transfers allowed.
REQ-024 Width rule: sum is WIDTH bits modulo 2^WIDTH; carry-out is discarded.
REQ-025 en deassertion mid-stream does not cancel in-flight tags; they complete normally.
REQ-026 Requester holding valid with changing operands before grant: the operands sampled in the transfer cycle are used.

Reset
REQ-027 rst_n low asynchronously clears: pointer to 0 (requester 0 first), all tags invalid, resp_valid0/1 = 0, resp_sum = 0, cnt0/cnt1 = 0.
REQ-028 Ops in flight at reset are dropped; no response is ever produced for them, even if add_sum later changes.
REQ-029 First grant is possible in the first cycle with rst_n high.

Configuration
REQ-030 Macro ADD_ARBITER_STATS_EN defined: cntk increments by 1 on each transfer of requester k, saturating at 16'hFFFF.
REQ-031 Macro ADD_ARBITER_STATS_EN undefined: no counter registers; cnt0 and cnt1 tied to 0; all other behaviour identical.

Verification
REQ-032 Single op: after reset, valid0 with x=5, y=7, en=1, LATENCY=2 -> ready0 high in cycle 0; resp_valid0 high with resp_sum=12 two edges after the transfer; resp_valid1 never asserts.
REQ-033 Contention: both valid continuously for 4 cycles -> grants 0,1,0,1; responses alternate requester id with correct sums; cnt0=cnt1=2 with STATS_EN.
REQ-034 Wrap: x=0x7FFF, y=0x0001, WIDTH=15 -> resp_sum=0x0000.
REQ-035 Reset mid-flight: transfer at cycle 0, rst_n pulsed low in cycle 1 -> no resp_valid at any later cycle; pointer back to 0.
REQ-036 en drop: transfer at cycle 0, en low from cycle 1 with both valid -> no further ready; the cycle-0 response still arrives after LATENCY edges.
REQ-037 Counter saturation (STATS_EN): 65537 transfers on requester 0 -> cnt0=16'hFFFF.

Source files
------------

// File: rtl/add_arbiter.sv
// Two-requester round-robin front end for a shared pipelined adder, with tagged response routing.
// Optional per-requester issue counters are built when ADD_ARBITER_STATS_EN is defined.
module add_arbiter #(
    parameter int unsigned WIDTH   = 15,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req_valid0,
    input  logic             req_valid1,
    output logic             req_ready0,
    output logic             req_ready1,
    input  logic [WIDTH-1:0] req_x0,
    input  logic [WIDTH-1:0] req_y0,
    input  logic [WIDTH-1:0] req_x1,
    input  logic [WIDTH-1:0] req_y1,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    input  logic [WIDTH-1:0] add_sum,
    output logic             resp_valid0,
    output logic             resp_valid1,
    output logic [WIDTH-1:0] resp_sum,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    localparam int unsigned CNT_W = 16;

    logic               gnt0_c;
    logic               gnt1_c;
    logic               xfer_c;
    logic               ptr_q,   ptr_d;
    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;
    logic               resp_valid0_q, resp_valid0_d;
    logic               resp_valid1_q, resp_valid1_d;
    logic [WIDTH-1:0]   resp_sum_q,    resp_sum_d;

    // Grant, operand mux, pointer update and tag pipeline advance
    always_comb begin
        gnt0_c = en & req_valid0 & (~req_valid1 | ~ptr_q);
        gnt1_c = en & req_valid1 & (~req_valid0 |  ptr_q);
        xfer_c = gnt0_c | gnt1_c;

        add_x = '0;
        add_y = '0;
        if (gnt0_c) begin
            add_x = req_x0;
            add_y = req_y0;
        end else if (gnt1_c) begin
            add_x = req_x1;
            add_y = req_y1;
        end

        ptr_d = ptr_q;
        if (gnt0_c) begin
            ptr_d = 1'b1;
        end else if (gnt1_c) begin
            ptr_d = 1'b0;
        end

        // Stage 0 takes this cycle's transfer; the oldest stage falls off the top
        tag_v_d  = LATENCY'({tag_v_q,  xfer_c});
        tag_id_d = LATENCY'({tag_id_q, gnt1_c});

        resp_valid0_d = tag_v_q[LATENCY-1] & ~tag_id_q[LATENCY-1];
        resp_valid1_d = tag_v_q[LATENCY-1] &  tag_id_q[LATENCY-1];
        resp_sum_d    = tag_v_q[LATENCY-1] ? add_sum : resp_sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= 1'b0;
            tag_v_q       <= '0;
            tag_id_q      <= '0;
            resp_valid0_q <= 1'b0;
            resp_valid1_q <= 1'b0;
            resp_sum_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            tag_v_q       <= tag_v_d;
            tag_id_q      <= tag_id_d;
            resp_valid0_q <= resp_valid0_d;
            resp_valid1_q <= resp_valid1_d;
            resp_sum_q    <= resp_sum_d;
        end
    end

    assign req_ready0  = gnt0_c;
    assign req_ready1  = gnt1_c;
    assign resp_valid0 = resp_valid0_q;
    assign resp_valid1 = resp_valid1_q;
    assign resp_sum    = resp_sum_q;

`ifdef ADD_ARBITER_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Saturating issue counters
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0_c && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (gnt1_c && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = CNT_W'(0);
    assign cnt1 = CNT_W'(0);
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: vector table for arbitration plus a response scoreboard.
module tb_add_arbiter;

    localparam int unsigned W   = 15;
    localparam int unsigned LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         req_valid0, req_valid1;
    logic         req_ready0, req_ready1;
    logic [W-1:0] req_x0, req_y0, req_x1, req_y1;
    logic [W-1:0] add_x, add_y, add_sum;
    logic         resp_valid0, resp_valid1;
    logic [W-1:0] resp_sum;
    logic [15:0]  cnt0, cnt1;

    add_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .add_x(add_x), .add_y(add_y), .add_sum(add_sum),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1), .resp_sum(resp_sum),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared pipelined adder
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= W'(add_x + add_y);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_sum = pipe[LAT-1];

    typedef struct {
        logic         en, v0, v1;
        logic [W-1:0] x0, y0, x1, y1;
        logic         r0, r1;
    } vec_t;

    typedef struct {
        int           due;
        logic         id;
        logic [W-1:0] sum;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_cnt0 = '0;
    logic [15:0] exp_cnt1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Response monitor: each cycle either the head entry is due or no strobe may appear
    initial begin
        exp_t e;
        logic ev0, ev1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                ev0 = 1'b0;
                ev1 = 1'b0;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    ev0 = ~e.id;
                    ev1 = e.id;
                    check("resp_sum", 32'(resp_sum), 32'(e.sum));
                end
                check("resp_valid0", 32'(resp_valid0), 32'(ev0));
                check("resp_valid1", 32'(resp_valid1), 32'(ev1));
            end
        end
    end

    // Called at a negedge: drive, check grant and adder operands, log expected response
    task automatic step(input vec_t v);
        logic [W-1:0] ex, ey;
        en = v.en; req_valid0 = v.v0; req_valid1 = v.v1;
        req_x0 = v.x0; req_y0 = v.y0; req_x1 = v.x1; req_y1 = v.y1;
        #1;
        ex = v.r0 ? v.x0 : (v.r1 ? v.x1 : '0);
        ey = v.r0 ? v.y0 : (v.r1 ? v.y1 : '0);
        check("req_ready0", 32'(req_ready0), 32'(v.r0));
        check("req_ready1", 32'(req_ready1), 32'(v.r1));
        check("add_x", 32'(add_x), 32'(ex));
        check("add_y", 32'(add_y), 32'(ey));
        if (v.r0 || v.r1) begin
            sb.push_back('{due: cyc + 1 + LAT, id: v.r1, sum: W'(ex + ey)});
            if (v.r0) exp_cnt0 = sat_inc(exp_cnt0);
            else      exp_cnt1 = sat_inc(exp_cnt1);
        end
        @(negedge clk);
    endtask

    task automatic check_cnts(input string tag);
`ifdef ADD_ARBITER_STATS_EN
        check({tag, "_cnt0"}, 32'(cnt0), 32'(exp_cnt0));
        check({tag, "_cnt1"}, 32'(cnt1), 32'(exp_cnt1));
`else
        check({tag, "_cnt0"}, 32'(cnt0), 32'(0));
        check({tag, "_cnt1"}, 32'(cnt1), 32'(0));
`endif
    endtask

    vec_t vecs[11];
    vec_t idle;
    vec_t v;

    initial begin
        // en, v0, v1, x0, y0, x1, y1, ready0, ready1
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 15'd5,      15'd7,      15'd0,      15'd0,      1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 15'd9,      15'd9,      15'd100,    15'd23,     1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 15'h7FFF,   15'h0001,   15'd200,    15'd300,    1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 15'h1234,   15'h4321,   15'h7FFF,   15'h7FFF,   1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 15'd3,      15'd4,      15'd5,      15'd6,      1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 15'd11,     15'd12,     15'd13,     15'd14,     1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 15'd20,     15'd22,     15'd0,      15'd0,      1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 15'd0,      15'd0,      15'd40,     15'd2,      1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 15'd1,      15'd1,      15'd1,      15'd1,      1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 15'd50,     15'd60,     15'd70,     15'd80,     1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 15'd6,      15'd6,      15'd7,      15'd7,      1'b0, 1'b1};
        idle     = '{1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid0", 32'(resp_valid0), 32'(0));
        check("rst_resp_valid1", 32'(resp_valid1), 32'(0));
        check("rst_resp_sum", 32'(resp_sum), 32'(0));
        check("rst_ready0", 32'(req_ready0), 32'(0));
        check_cnts("rst");

        // First grant in the first cycle after reset release
        rst_n = 1'b1;
        mon_en = 1'b1;
        foreach (vecs[i]) step(vecs[i]);
        repeat (LAT + 1) step(idle);
        check_cnts("table");

        // en drop: one transfer, then both valid with en low; response still arrives
        v = '{1'b1, 1'b1, 1'b0, 15'd1000, 15'd234, 15'd0, 15'd0, 1'b1, 1'b0};
        step(v);
        v = '{1'b0, 1'b1, 1'b1, 15'd1, 15'd2, 15'd3, 15'd4, 1'b0, 1'b0};
        repeat (4) step(v);

        // Reset mid-flight: transfer, then pulse reset; no response may follow
        v = '{1'b1, 1'b1, 1'b0, 15'd77, 15'd88, 15'd0, 15'd0, 1'b1, 1'b0};
        step(v);
        en = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        #2;
        rst_n = 1'b1;
        check("midrst_resp_sum", 32'(resp_sum), 32'(0));
        check_cnts("midrst");
        @(negedge clk);
        repeat (LAT + 2) step(idle);
        // Pointer must be back at requester 0
        v = '{1'b1, 1'b1, 1'b1, 15'd10, 15'd20, 15'd30, 15'd40, 1'b1, 1'b0};
        step(v);

`ifdef ADD_ARBITER_STATS_EN
        v = '{1'b1, 1'b1, 1'b0, 15'd1, 15'd2, 15'd0, 15'd0, 1'b1, 1'b0};
        for (int n = 0; n < 65537; n++) begin
            v.x0 = W'($urandom);
            step(v);
        end
`endif

        for (int k = 0; k < LAT + 4 && sb.size() > 0; k++) step(idle);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        check_cnts("final");
`ifdef ADD_ARBITER_STATS_EN
        check("sat_cnt0", 32'(cnt0), 32'(16'hFFFF));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
